// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the sram arbiter slice: FSM state encodings and the
// requester-index width helper.
package sram_ctrl_pkg;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// otherwise the lowest asserted request (the wrap-around case).
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic           hit_hi, hit_lo;
    logic [IDW-1:0] idx_hi, idx_lo;

    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        // Walk downward so the lowest qualifying index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDW'(i) >= ptr)) begin
                hit_hi = 1'b1;
                idx_hi = IDW'(i);
            end
            if (req[i]) begin
                hit_lo = 1'b1;
                idx_lo = IDW'(i);
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = hit_hi ? idx_hi : idx_lo;
        if (hit_hi || hit_lo)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one single-port sram among NUM_REQ requesters, with a
// post-reset clear sweep over every address before any request is accepted.
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_REQ    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             init_done,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wd,
    output logic                             mem_banksel,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic                             mem_rst,
    input  logic [DATA_WIDTH-1:0]            mem_dataout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int IDW   = idw(NUM_REQ);

    logic                                 state, state_nxt;
    logic [ADDR_WIDTH:0]                  sweep_cnt;
    logic [IDW-1:0]                       rr_ptr, grant_idx;
    logic [NUM_REQ-1:0]                   grant, req_live;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_a;
    logic                                 granted, rd_grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Requests are invisible during the sweep and while rst is held.
    assign req_live = (state == ST_RUN && !rst) ? req_valid : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req       (req_live),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign granted  = |grant;
    assign rd_grant = granted && !req_write[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && sweep_cnt == (ADDR_WIDTH+1)'(DEPTH - 1))
            state_nxt = ST_RUN;
    end

    always_comb begin
        req_ready   = grant;
        mem_address = '0;
        mem_wd      = '0;
        mem_banksel = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_rst     = 1'b0;
        if (state == ST_INIT) begin
            mem_rst     = 1'b1;
            mem_address = sweep_cnt[ADDR_WIDTH-1:0];
        end else if (granted) begin
            mem_address = addr_a[grant_idx];
            mem_wd      = wdata_a[grant_idx];
            mem_banksel = 1'b1;
            mem_write   = req_write[grant_idx];
            mem_read    = ~req_write[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + (ADDR_WIDTH+1)'(1);
                if (state_nxt == ST_RUN)
                    init_done <= 1'b1;
            end
            if (granted)
                rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
            // sram read is combinational, so data is captured in the grant cycle.
            if (rd_grant) begin
                rsp_valid <= grant;
                rsp_data  <= mem_dataout;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural sram attached and a
// queue-free reference model (rotating priority + shadow memory).
module tb_sram_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_data, mem_wd, mem_dataout;
    logic [AW-1:0]     mem_address;
    logic              init_done, mem_banksel, mem_read, mem_write, mem_rst;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] m_mem [DEPTH];
    logic [NR-1:0] m_rsp_v;
    logic [DW-1:0] m_rsp_d;
    logic [NR-1:0] exp_g, exp_rv;
    logic [DW-1:0] exp_rd;

    // Outstanding request held by each requester until accepted
    logic          pend_v [NR];
    logic          pend_w [NR];
    logic [AW-1:0] pend_a [NR];
    logic [DW-1:0] pend_d [NR];

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
        .mem_address(mem_address), .mem_wd(mem_wd), .mem_banksel(mem_banksel),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rst(mem_rst),
        .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Attached sram: combinational read, per-address clear, synchronous write
    logic [DW-1:0] sram [DEPTH];
    assign mem_dataout = sram[mem_address];
    always @(posedge clk) begin
        if (mem_rst) sram[mem_address] <= '0;
        else if (mem_banksel && mem_write) sram[mem_address] <= mem_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [NR-1:0] m_grant(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (((v >> idx) & NR'(1)) != 0) return NR'(1) << idx;
        end
        return '0;
    endfunction

    task automatic m_commit(input logic [NR-1:0] g);
        logic [AW-1:0] a;
        m_rsp_v = '0;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                a = req_addr[i*AW +: AW];
                if (req_write[i]) m_mem[a] = req_wdata[i*DW +: DW];
                else begin
                    m_rsp_v = g;
                    m_rsp_d = m_mem[a];
                end
                m_ptr = (i + 1) % NR;
            end
        end
    endtask

    task automatic model_cleared();
        m_ptr = 0; m_rsp_v = '0; m_rsp_d = '0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    endtask

    task automatic clear_pend();
        for (int i = 0; i < NR; i++) begin
            pend_v[i] = 1'b0; pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
        end
    endtask

    task automatic arm(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_v[i] = 1'b1; pend_w[i] = w; pend_a[i] = a; pend_d[i] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = pend_v[i];
            req_write[i] = pend_w[i];
            req_addr[i*AW +: AW]  = pend_a[i];
            req_wdata[i*DW +: DW] = pend_d[i];
        end
    endtask

    task automatic sample();
        drive();
        @(negedge clk);
        exp_g = m_grant(req_valid); exp_rv = m_rsp_v; exp_rd = m_rsp_d;
    endtask

    task automatic advance();
        m_commit(exp_g);
        for (int i = 0; i < NR; i++) if (exp_g[i]) pend_v[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_and_sweep();
        clear_pend(); drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (DEPTH) @(posedge clk);
        #1 model_cleared();
    endtask

    task automatic test_reset();
        clear_pend(); drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, init_done, mem_banksel, mem_read, mem_write} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {req_ready, rsp_valid, init_done, mem_banksel, mem_read, mem_write});
        end
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        checks++;
        if (mem_rst !== 1'b1 || mem_address !== '0) begin
            errors++; $display("FAIL reset_sweep_hold: mem_rst=%b addr=%0d required 1/0", mem_rst, mem_address);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            checks++;
            if (mem_rst !== 1'b1 || mem_address !== AW'(c - 1) || init_done !== 1'b0 || mem_banksel !== 1'b0) begin
                errors++; $display("FAIL sweep_cycle%0d: mem_rst=%b addr=%0d init_done=%b required 1/%0d/0", c, mem_rst, mem_address, init_done, c - 1);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || mem_rst !== 1'b0) begin
            errors++; $display("FAIL init_done_cycle17: init_done=%b mem_rst=%b required 1/0", init_done, mem_rst);
        end
        @(posedge clk); #1;
        model_cleared();
        for (int a = 0; a <= DEPTH; a++) begin
            if (a < DEPTH) arm(0, 1'b0, AW'(a), '0);
            sample();
            checks++;
            if (req_ready !== exp_g) begin errors++; $display("FAIL clear_read_ready a=%0d: got %b required %b", a, req_ready, exp_g); end
            if (exp_rv != '0) begin
                checks++;
                if (rsp_valid !== exp_rv || rsp_data !== '0) begin
                    errors++; $display("FAIL cleared_word a=%0d: got v=%b d=%h required v=%b d=0", a - 1, rsp_valid, rsp_data, exp_rv);
                end
            end
            advance();
        end
    endtask

    task automatic test_write_read();
        arm(0, 1'b1, 4'd3, 32'hDEADBEEF);
        sample();
        checks++;
        if (req_ready !== 2'b01 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_banksel !== 1'b1 ||
            mem_address !== 4'd3 || mem_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_pins: ready=%b w=%b r=%b bs=%b addr=%0d wd=%h required 01/1/0/1/3/deadbeef", req_ready, mem_write, mem_read, mem_banksel, mem_address, mem_wd);
        end
        advance();
        arm(0, 1'b0, 4'd3, '0);
        sample();
        checks++;
        if (req_ready !== 2'b01 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 4'd3) begin
            errors++; $display("FAIL read_pins: ready=%b r=%b w=%b addr=%0d required 01/1/0/3", req_ready, mem_read, mem_write, mem_address);
        end
        advance();
        sample();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL raw_response: v=%b d=%h required 01/deadbeef", rsp_valid, rsp_data);
        end
        checks++;
        if (mem_banksel !== 1'b0 || mem_address !== '0 || mem_wd !== '0) begin
            errors++; $display("FAIL idle_pins: bs=%b addr=%0d wd=%h required 0/0/0", mem_banksel, mem_address, mem_wd);
        end
        advance();
        sample();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rsp_single_pulse_hold: v=%b d=%h required 00/deadbeef", rsp_valid, rsp_data);
        end
        advance();
    endtask

    task automatic test_alternate();
        reset_and_sweep();
        arm(0, 1'b1, 4'd1, 32'hA1A1_0001);
        arm(1, 1'b1, 4'd2, 32'hB2B2_0002);
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (req_ready !== ((k == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL setup_write%0d: ready=%b required %b", k, req_ready, (k == 0) ? 2'b01 : 2'b10);
            end
            advance();
        end
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                if (!pend_v[0]) arm(0, 1'b0, 4'd1, '0);
                if (!pend_v[1]) arm(1, 1'b0, 4'd2, '0);
            end else clear_pend();
            sample();
            if (k < 8) begin
                checks++;
                if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL alternate_grant k=%0d: got %b required %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
                    errors++; $display("FAIL alternate_rsp k=%0d: v=%b d=%h required %b/%h", k, rsp_valid, rsp_data, exp_rv, exp_rd);
                end
            end
            advance();
        end
    endtask

    task automatic test_single_req1();
        reset_and_sweep();
        for (int k = 0; k < 3; k++) begin
            arm(1, 1'b0, AW'(k + 5), '0);
            sample();
            checks++;
            if (req_ready !== 2'b10) begin errors++; $display("FAIL req1_only k=%0d: got %b required 10", k, req_ready); end
            advance();
        end
        arm(0, 1'b0, 4'd0, '0);
        arm(1, 1'b0, 4'd8, '0);
        sample();
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL ptr_wrap_req0_first: got %b required 01", req_ready); end
        advance();
        sample();
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL ptr_wrap_req1_next: got %b required 10", req_ready); end
        advance();
        clear_pend();
    endtask

    task automatic test_init_hold();
        clear_pend(); drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            if (c == 5) arm(0, 1'b0, 4'd9, '0);
            drive();
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || init_done !== 1'b0) begin
                errors++; $display("FAIL init_hold c=%0d: ready=%b init_done=%b required 00/0", c, req_ready, init_done);
            end
            @(posedge clk); #1;
        end
        model_cleared();
        sample();
        checks++;
        if (init_done !== 1'b1 || req_ready !== 2'b01) begin
            errors++; $display("FAIL first_run_accept: init_done=%b ready=%b required 1/01", init_done, req_ready);
        end
        advance();
        sample();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== '0) begin
            errors++; $display("FAIL held_read_rsp: v=%b d=%h required 01/0", rsp_valid, rsp_data);
        end
        advance();
    endtask

    task automatic test_reset_mid_read();
        reset_and_sweep();
        arm(0, 1'b1, 4'd7, 32'h55AA_33CC);
        sample(); advance();
        arm(0, 1'b0, 4'd7, '0);
        sample();
        checks++;
        if (req_ready !== 2'b01 || mem_read !== 1'b1) begin
            errors++; $display("FAIL pre_reset_read: ready=%b r=%b required 01/1", req_ready, mem_read);
        end
        advance();
        clear_pend(); drive();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== '0 || init_done !== 1'b0) begin
            errors++; $display("FAIL reset_kills_rsp: v=%b d=%h init_done=%b required 00/0/0", rsp_valid, rsp_data, init_done);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            checks++;
            if (mem_rst !== 1'b1 || mem_address !== AW'(c - 1) || rsp_valid !== 2'b00) begin
                errors++; $display("FAIL resweep c=%0d: mem_rst=%b addr=%0d v=%b required 1/%0d/00", c, mem_rst, mem_address, rsp_valid, c - 1);
            end
            @(posedge clk); #1;
        end
        model_cleared();
        arm(0, 1'b0, 4'd7, '0);
        sample(); advance();
        sample();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== '0) begin
            errors++; $display("FAIL data_cleared_by_resweep: v=%b d=%h required 01/0", rsp_valid, rsp_data);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) != 0)
                    arm(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), $urandom);
                else if (pend_v[i] && $urandom_range(0, 9) == 0)
                    pend_v[i] = 1'b0;
            end
            sample();
            checks++;
            if (req_ready !== exp_g || mem_banksel !== (|exp_g)) begin
                errors++; $display("FAIL rand_grant n=%0d: ready=%b bs=%b required %b", n, req_ready, mem_banksel, exp_g);
            end
            checks++;
            if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd)) begin
                errors++; $display("FAIL rand_rsp n=%0d: v=%b d=%h required %b/%h", n, rsp_valid, rsp_data, exp_rv, exp_rd);
            end
            advance();
        end
        clear_pend();
    endtask

    initial begin
        rst = 1'b1;
        clear_pend(); drive();
        model_cleared();
        exp_g = '0; exp_rv = '0; exp_rd = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_single_req1();
        test_init_hold();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
